// File: rtl/rr_sel_scheduler.sv
// Round-robin scheduler feeding a 4-to-16 select decoder: one grant at a time,
// programmable hold length, and a one-cycle dead gap between grants.
module rr_sel_scheduler #(
  parameter int N     = 16,
  parameter int IDXW  = 4,
  parameter int HOLDW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [HOLDW-1:0] hold_cycles,
  input  logic             rel,          // early release; "release" is a reserved word
  output logic             enable,
  output logic [IDXW-1:0]  in,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  ptr, ptr_nxt;
  logic [IDXW-1:0]  in_nxt;
  logic [HOLDW-1:0] cnt, cnt_nxt;
  logic [IDXW-1:0]  pick, idx;
  logic             found;

  // Rotating first-set scan starting at ptr; the 4-bit add wraps 15 -> 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + i[IDXW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    in_nxt    = in;
    case (state)
      GRANT: begin
        if (!req[in] || rel || cnt == HOLDW'(1)) begin
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt - HOLDW'(1);
        end
      end
      default: begin
        if (found) begin
          state_nxt = GRANT;
          in_nxt    = pick;
          cnt_nxt   = (hold_cycles == '0) ? HOLDW'(1) : hold_cycles;
          ptr_nxt   = pick + IDXW'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Outputs are registered copies of the next state so nothing is combinational to the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      in     <= '0;
      enable <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      in     <= in_nxt;
      enable <= (state_nxt == GRANT);
      busy   <= (state_nxt == GRANT);
    end
  end

endmodule

// File: tb/tb_rr_sel_scheduler.sv
// Bench for rr_sel_scheduler: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural grant model.
module tb_rr_sel_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic [3:0]  hold_cycles = '0;
  logic        rel = 1'b0;
  logic        enable;
  logic [3:0]  in;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  rr_sel_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .hold_cycles(hold_cycles),
    .rel(rel), .enable(enable), .in(in), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a grant is (who, cycles left); with no grant, look for the next
  // requester round-robin. Any grant end leaves one idle cycle automatically.
  int m_en = 0, m_in = 0, m_ptr = 0, m_left = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_en = 0; m_in = 0; m_ptr = 0; m_left = 0;
    end else if (m_en == 1) begin
      if (!req[m_in] || rel || m_left == 1) m_en = 0;
      else m_left = m_left - 1;
    end else begin
      for (int j = 0; j < 16; j++) begin
        int k;
        k = (m_ptr + j) % 16;
        if (req[k]) begin
          m_en = 1; m_in = k;
          m_left = (hold_cycles == 0) ? 1 : int'(hold_cycles);
          m_ptr = (k + 1) % 16;
          break;
        end
      end
    end
    #1;
    chk("model_enable", enable, m_en);
    chk("model_in", in, m_in);
    chk("model_busy", busy, m_en);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; rel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_enable", enable, 0);
    chk("rst_in", in, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bit exp1[5] = '{1, 1, 1, 0, 1};

    // Single requester, hold 3, then gap, then regrant.
    do_reset();
    req = 16'h0001; hold_cycles = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_enable", enable, exp1[i]);
      chk("t1_in", in, 0);
    end

    // All requesting, hold 1: 0..15 then wrap to 0, gap between each.
    do_reset();
    req = 16'hFFFF; hold_cycles = 4'd1;
    for (int g = 0; g < 17; g++) begin
      @(negedge clk);
      chk("t2_enable", enable, 1);
      chk("t2_in", in, g % 16);
      @(negedge clk);
      chk("t2_gap", enable, 0);
    end

    // Two requesters at the ends, hold 0 acts as 1.
    do_reset();
    req = 16'h8001; hold_cycles = 4'd0;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      chk("t3_enable", enable, 1);
      chk("t3_in", in, (g % 2) ? 15 : 0);
      @(negedge clk);
      chk("t3_gap", enable, 0);
    end

    // Early release on the third grant cycle.
    do_reset();
    req = 16'h0420; hold_cycles = 4'd10;
    @(negedge clk); chk("t4_in", in, 5); chk("t4_en1", enable, 1);
    @(negedge clk); chk("t4_en2", enable, 1);
    @(negedge clk); chk("t4_en3", enable, 1);
    rel = 1'b1;
    @(negedge clk); chk("t4_gap", enable, 0);
    rel = 1'b0;
    @(negedge clk); chk("t4_next_en", enable, 1); chk("t4_next_in", in, 10);

    // Requester withdraws on the fourth grant cycle.
    do_reset();
    req = 16'h0004; hold_cycles = 4'd8;
    @(negedge clk); chk("t5_in", in, 2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); chk("t5_en4", enable, 1);
    req = 16'h0010;
    @(negedge clk); chk("t5_gap", enable, 0); chk("t5_gap_in", in, 2);
    @(negedge clk); chk("t5_next_en", enable, 1); chk("t5_next_in", in, 4);

    // Asynchronous reset mid-grant.
    do_reset();
    req = 16'h0080; hold_cycles = 4'd15;
    @(negedge clk);
    @(negedge clk); chk("t6_en", enable, 1); chk("t6_in", in, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_en", enable, 0);
    chk("t6_async_in", in, 0);
    chk("t6_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); chk("t6_regrant_en", enable, 1); chk("t6_regrant_in", in, 7);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: req = '0;
          1: req = 16'(1) << $urandom_range(0, 15);
          2: req = 16'($urandom);
          default: req = 16'($urandom & $urandom);
        endcase
      end
      hold_cycles = 4'($urandom);
      rel = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_sel_scheduler.md
Name: rr_sel_scheduler

Overview:
- Round-robin scheduler directly upstream of the 4-to-16 select decoder.
- Arbitrates among 16 request lines and drives the decoder's enable and 4-bit index, so that exactly one select line is active at a time.
- Each grant is held for a programmable number of cycles.
- A mandatory one-cycle dead gap between grants gives break-before-make on the decoded sel lines.

Parameters:
- N, 16, number of requesters; fixed at 16 to match the decoder.
- IDXW, 4, index width; equals log2(N).
- HOLDW, 4, width of the hold-length input.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  16  request vector; bit k set means requester k wants the select.
- hold_cycles  input  4  grant length in cycles, sampled at grant start; value 0 is treated as 1.
- release  input  1  granted requester ends its grant early.
- enable  output  1  decoder enable; registered.
- in  output  4  decoder index; registered.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset (async, rst_n=0):
  - enable=0, in=0, busy=0.
  - state=IDLE, ptr=0, cnt=0.
  - Takes effect immediately, including mid-grant.
  - Outputs stay 0 until the first clk edge with rst_n=1 and req!=0.
- All outputs come from flops. No combinational path from any input to any output.
- States and outputs:
  - IDLE: enable=0.
  - GRANT: enable=1, busy=1.
  - GAP: enable=0.
- Arbitration (in IDLE and GAP):
  - Choose the first set bit of req scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1.
  - If req==0, stay in/go to IDLE with no state change.
  - Otherwise, at the next edge: state=GRANT, in=k, enable=1, cnt=max(hold_cycles,1), ptr=(k+1) mod 16.
  - ptr wraps from 15 to 0.
- Latency: request sampled at edge t gives enable=1 and in=k visible after edge t, i.e. one cycle of latency.
- GRANT, evaluated each edge in priority order:
  1. req[in]==0 (requester withdrew) → GAP.
  2. release==1 → GAP.
  3. cnt==1 → GAP.
  4. Otherwise cnt=cnt-1, stay in GRANT.
- Grant duration:
  - Exactly max(hold_cycles,1) cycles of enable=1 when not cut short.
  - hold_cycles changes during GRANT are ignored.
- Leaving GRANT:
  - enable drops at the same edge that enters GAP.
  - `in` holds its last value while enable=0.
- GAP: exactly one cycle with enable=0. It arbitrates as IDLE does, so back-to-back grants are spaced by exactly one dead cycle.
- New requests during GRANT do not preempt. They are considered only in GAP/IDLE.
- release while not in GRANT is ignored.
- Invariants:
  - enable=1 is never held for more than 15 consecutive cycles.
  - `in` never changes while enable=1.

Test Plan:
- Reset, then req=16'h0001, hold_cycles=3 → enable=1 and in=0 after the next edge for exactly 3 cycles; then 1 GAP cycle (enable=0); then regrant to 0 with ptr=1.
- req=16'hFFFF held, hold_cycles=1 → grants in order 0,1,2,...,15,0, each 1 cycle with enable=1 followed by 1 cycle with enable=0; wrap 15→0 verified.
- req=16'h8001 constant, hold_cycles=0 → grants alternate 0,15,0,15, each exactly 1 cycle (0 treated as 1).
- Grant to 5 with hold_cycles=10; release=1 on the 3rd grant cycle → enable=0 after that edge; next grant goes to the lowest req index ≥6 (or wrapped).
- Grant to 2 with hold_cycles=8; drop req[2] on the 4th cycle → enable falls at the next edge, followed by the GAP cycle.
- Assert rst_n=0 mid-grant (in=7, enable=1) → enable=0, in=0, busy=0 immediately without waiting for a clock edge; after release with req=16'h0080, the next grant goes to 7 starting from ptr=0.
